// File: rtl/bep_pkg.sv
// bep_pkg: shared widths and default timing constants for the edge front end and pulse timer
package bep_pkg;
    localparam int TIMER_W           = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 3;
    localparam int DEF_IDLE_CYCLES   = 255;
    localparam int MIN_TIMING        = 9;
    localparam int MAX_TIMING        = 18;
endpackage

// File: rtl/bep_sync_chain.sv
// bep_sync_chain: STAGES-deep flop chain bringing an asynchronous input into the clock domain
module bep_sync_chain import bep_pkg::*; #(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q, chain_d;
    // shift the raw input one stage deeper each clock
    always_comb chain_d = {chain_q[STAGES-2:0], d};
    // chain register, cleared asynchronously
    always_ff @(posedge clock or posedge reset)
        if (reset) chain_q <= '0;
        else       chain_q <= chain_d;
    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/input_edge_conditioner.sv
// input_edge_conditioner: synchronise, debounce and edge-detect digital_in, flag idle line
// optional glitch_count output enabled by defining BEP_GLITCH_COUNT_EN
module input_edge_conditioner import bep_pkg::*; #(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int IDLE_CYCLES   = DEF_IDLE_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               digital_in,
    output logic               filtered_out,
    output logic               pos_edge,
    output logic               neg_edge,
    output logic               line_idle
`ifdef BEP_GLITCH_COUNT_EN
    ,
    output logic [TIMER_W-1:0] glitch_count
`endif
);
    localparam logic [TIMER_W-1:0] FCNT_MAX = TIMER_W'(FILTER_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ICNT_MAX = TIMER_W'(IDLE_CYCLES);
    logic               synced, differ, commit;
    logic               level_q, level_d, pos_q, pos_d, neg_q, neg_d;
    logic [TIMER_W-1:0] fcnt_q, fcnt_d, icnt_q, icnt_d;

    bep_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (digital_in),
        .q     (synced)
    );

    // accept a new level only after it has disagreed for FILTER_CYCLES synced samples
    always_comb begin
        differ  = synced != level_q;
        commit  = differ && fcnt_q == FCNT_MAX;
        level_d = commit ? synced : level_q;
        fcnt_d  = (!differ || commit) ? '0 : fcnt_q + 1'b1;
        pos_d   = commit && synced;
        neg_d   = commit && !synced;
        icnt_d  = commit ? '0 : (icnt_q == ICNT_MAX ? icnt_q : icnt_q + 1'b1);
    end

    // filter, strobe and idle state
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            level_q <= 1'b0;
            fcnt_q  <= '0;
            icnt_q  <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            icnt_q  <= icnt_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end

    assign filtered_out = level_q;
    assign pos_edge     = pos_q;
    assign neg_edge     = neg_q;
    assign line_idle    = icnt_q == ICNT_MAX;

`ifdef BEP_GLITCH_COUNT_EN
    logic [TIMER_W-1:0] gcnt_q, gcnt_d;
    // a glitch is a partial count abandoned because synced fell back to the level
    always_comb gcnt_d = (!differ && fcnt_q != '0 && gcnt_q != '1) ? gcnt_q + 1'b1 : gcnt_q;
    // saturating glitch counter, cleared only by reset
    always_ff @(posedge clock or posedge reset)
        if (reset) gcnt_q <= '0;
        else       gcnt_q <= gcnt_d;
    assign glitch_count = gcnt_q;
`endif
endmodule

// File: tb/tb_input_edge_conditioner.sv
// tb_input_edge_conditioner: randomized and directed checks of two conditioner instances against a run-length model
module tb_input_edge_conditioner;
    localparam int IDLE = 255;
    localparam int FC0  = 3;

    logic clock, reset, din0, din1;
    logic fo0, pe0, ne0, li0, fo1, pe1, ne1, li1;
`ifdef BEP_GLITCH_COUNT_EN
    logic [7:0] gc0, gc1;
`endif
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    input_edge_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(FC0), .IDLE_CYCLES(IDLE)) dut0 (
        .clock(clock), .reset(reset), .digital_in(din0), .filtered_out(fo0),
        .pos_edge(pe0), .neg_edge(ne0), .line_idle(li0)
`ifdef BEP_GLITCH_COUNT_EN
        , .glitch_count(gc0)
`endif
    );
    input_edge_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .IDLE_CYCLES(IDLE)) dut1 (
        .clock(clock), .reset(reset), .digital_in(din1), .filtered_out(fo1),
        .pos_edge(pe1), .neg_edge(ne1), .line_idle(li1)
`ifdef BEP_GLITCH_COUNT_EN
        , .glitch_count(gc1)
`endif
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // model: samples seen by the filter lag the pin by two edges; a level is accepted after
    // fc consecutive disagreeing samples; age counts edges since the last accepted edge
    typedef struct {
        bit [1:0] pipe;
        bit       lvl;
        int       run;
        int       age;
        int       glitches;
        bit       pos;
        bit       neg;
    } model_t;
    model_t m0, m1;

    function automatic model_t m_clear();
        model_t m;
        m.pipe = 0; m.lvl = 0; m.run = 0; m.age = 0; m.glitches = 0; m.pos = 0; m.neg = 0;
        return m;
    endfunction

    function automatic model_t m_step(model_t m, bit din, int fc);
        bit s;
        s = m.pipe[1];
        m.pipe = {m.pipe[0], din};
        m.pos = 0;
        m.neg = 0;
        if (s != m.lvl) begin
            m.run = m.run + 1;
            if (m.run == fc) begin
                m.lvl = s;
                m.run = 0;
                m.pos = s;
                m.neg = !s;
            end
        end else begin
            if (m.run > 0 && m.glitches < 255) m.glitches = m.glitches + 1;
            m.run = 0;
        end
        m.age = (m.pos || m.neg) ? 0 : (m.age < IDLE ? m.age + 1 : IDLE);
        return m;
    endfunction

    task automatic step(input bit d0, input bit d1);
        logic [3:0] exp0, exp1;
        din0 = d0;
        din1 = d1;
        @(posedge clock);
        m0 = m_step(m0, d0, FC0);
        m1 = m_step(m1, d1, 1);
        cyc++;
        #1;
        exp0 = {m0.lvl, m0.pos, m0.neg, m0.age == IDLE};
        exp1 = {m1.lvl, m1.pos, m1.neg, m1.age == IDLE};
        n_checks++;
        if ({fo0, pe0, ne0, li0} !== exp0) begin
            n_fail++;
            $display("FAIL model_dut0 cyc=%0d {filt,pos,neg,idle} got=%b exp=%b", cyc, {fo0, pe0, ne0, li0}, exp0);
        end
        n_checks++;
        if ({fo1, pe1, ne1, li1} !== exp1) begin
            n_fail++;
            $display("FAIL model_dut1 cyc=%0d {filt,pos,neg,idle} got=%b exp=%b", cyc, {fo1, pe1, ne1, li1}, exp1);
        end
`ifdef BEP_GLITCH_COUNT_EN
        n_checks++;
        if (gc0 !== 8'(m0.glitches) || gc1 !== 8'(m1.glitches)) begin
            n_fail++;
            $display("FAIL model_glitch cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, gc0, gc1, m0.glitches, m1.glitches);
        end
`endif
    endtask

    task automatic apply_reset();
        reset = 1;
        m0 = m_clear();
        m1 = m_clear();
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        din0 = 0;
        din1 = 0;
        reset = 1;
        m0 = m_clear();
        m1 = m_clear();
        #1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({fo0, pe0, ne0, li0, fo1, pe1, ne1, li1} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=00000000", {fo0, pe0, ne0, li0, fo1, pe1, ne1, li1});
        end
`ifdef BEP_GLITCH_COUNT_EN
        n_checks++;
        if (gc0 !== 8'd0 || gc1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_glitch got=%0d/%0d exp=0/0", gc0, gc1);
        end
`endif
        reset = 0;
        repeat (3) step(0, 0);
    endtask

    task automatic measure_rise(input string name);
        int first0 = -1, first1 = -1, npos = 0, nneg = 0;
        for (int e = 0; e < 20; e++) begin
            step(1, 1);
            if (fo0 && first0 < 0) first0 = e;
            if (fo1 && first1 < 0) first1 = e;
            if (pe0) npos++;
            if (ne0) nneg++;
        end
        n_checks++;
        if (first0 != 4 || first1 != 2) begin
            n_fail++;
            $display("FAIL %s_latency got=%0d/%0d exp=4/2", name, first0, first1);
        end
        n_checks++;
        if (npos != 1 || nneg != 0) begin
            n_fail++;
            $display("FAIL %s_strobes pos=%0d neg=%0d exp=1/0", name, npos, nneg);
        end
    endtask

    task automatic test_first_edge();
        measure_rise("first_edge");
    endtask

    task automatic test_pulse12();
        int pidx = -1, nidx = -1, high = 0;
        repeat (10) step(0, 0);
        for (int e = 0; e < 40; e++) begin
            step(e < 12, e < 12);
            if (pe0) pidx = e;
            if (ne0) nidx = e;
            if (fo0) high++;
        end
        n_checks++;
        if (pidx < 0 || nidx - pidx != 12 || high != 12) begin
            n_fail++;
            $display("FAIL pulse12 pos_at=%0d neg_at=%0d high=%0d exp spacing=12 high=12", pidx, nidx, high);
        end
    endtask

    task automatic test_glitch();
        int strobes = 0, highs = 0;
`ifdef BEP_GLITCH_COUNT_EN
        logic [7:0] g_before;
`endif
        repeat (5) step(0, 0);
`ifdef BEP_GLITCH_COUNT_EN
        g_before = gc0;
`endif
        repeat (2) step(1, 1);
        for (int e = 0; e < 10; e++) begin
            step(0, 0);
            if (pe0 || ne0) strobes++;
            if (fo0) highs++;
        end
        n_checks++;
        if (strobes != 0 || highs != 0) begin
            n_fail++;
            $display("FAIL glitch_reject strobes=%0d high=%0d exp=0/0", strobes, highs);
        end
`ifdef BEP_GLITCH_COUNT_EN
        n_checks++;
        if (gc0 !== g_before + 8'd1) begin
            n_fail++;
            $display("FAIL glitch_count got=%0d exp=%0d", gc0, g_before + 8'd1);
        end
`endif
    endtask

    task automatic test_idle();
        int seen = 0, first_idle = -1, dropped = 0, fell = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 1);
            if (pe0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL idle_edge_timeout got=no strobe exp=strobe within 10");
        end
        for (int i = 1; i <= 300; i++) begin
            step(1, 1);
            if (li0 && first_idle < 0) first_idle = i;
            if (i >= 255 && !li0) dropped++;
        end
        n_checks++;
        if (first_idle != 255 || dropped != 0) begin
            n_fail++;
            $display("FAIL idle_assert first=%0d dropped=%0d exp=255/0", first_idle, dropped);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 0);
            if (ne0) begin
                seen = 1;
                fell = !li0;
            end
        end
        n_checks++;
        if (!seen || !fell) begin
            n_fail++;
            $display("FAIL idle_drop strobe=%0d idle_low=%0d exp=1/1", seen, fell);
        end
    endtask

    task automatic test_async_reset();
        int strobes = 0;
        repeat (256) step(0, 0);
        repeat (4) step(1, 0);
        #2;
        reset = 1;
        din0 = 0;
        din1 = 0;
        #1;
        n_checks++;
        if ({fo0, pe0, ne0, li0} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=0000", {fo0, pe0, ne0, li0});
        end
        m0 = m_clear();
        m1 = m_clear();
        repeat (2) @(posedge clock);
        #1 reset = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            if (pe0 || ne0) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL post_reset_strobe got=%0d exp=0", strobes);
        end
        measure_rise("post_reset");
    endtask

    task automatic test_fc1();
        int first_pos = -1, count = 0, bad = 0, last = -1;
        bit last_pos = 0;
        repeat (6) step(0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, ((i / 2) % 2) == 0);
            if (pe1 || ne1) begin
                if (first_pos < 0 && pe1) first_pos = i;
                if (last >= 0 && (i - last != 2 || pe1 == last_pos)) bad++;
                last = i;
                last_pos = pe1;
                count++;
            end
        end
        n_checks++;
        if (first_pos != 2 || count != 19 || bad != 0) begin
            n_fail++;
            $display("FAIL fc1_toggle first=%0d count=%0d bad=%0d exp=2/19/0", first_pos, count, bad);
        end
`ifdef BEP_GLITCH_COUNT_EN
        n_checks++;
        if (gc1 !== 8'd0) begin
            n_fail++;
            $display("FAIL fc1_glitch got=%0d exp=0", gc1);
        end
`endif
    endtask

    task automatic test_random();
        bit d0 = 0, d1 = 0;
        int len0 = 0, len1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (len0 == 0) begin d0 = !d0; len0 = $urandom_range(1, 6); end
            if (len1 == 0) begin d1 = !d1; len1 = $urandom_range(1, 3); end
            step(d0, d1);
            len0--;
            len1--;
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_pulse12();
        test_glitch();
        test_idle();
        test_async_reset();
        test_fc1();
        test_random();
        apply_reset();
        test_first_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
